// File: rtl/iob_rr_arbiter_iob_pkg.sv
// Package for the IOb round-robin arbiter.
// Provides the FSM state type built from the encodings in
// iob_rr_arbiter_iob_conf.vh.
`include "iob_rr_arbiter_iob_conf.vh"

package iob_rr_arbiter_iob_pkg;

  typedef enum logic [1:0] {
    IDLE = `IOB_RR_ST_IDLE,
    REQ  = `IOB_RR_ST_REQ,
    RESP = `IOB_RR_ST_RESP
  } state_t;

endpackage

// File: rtl/iob_rr_arbiter_iob_conf.vh
// Shared configuration for the IOb round-robin arbiter.
// Holds the FSM state encodings and the response timeout limit so that
// the package, the RTL and any checker agree on the same values.
`ifndef IOB_RR_ARBITER_IOB_CONF_VH
`define IOB_RR_ARBITER_IOB_CONF_VH

`define IOB_RR_ST_IDLE        2'd0
`define IOB_RR_ST_REQ         2'd1
`define IOB_RR_ST_RESP        2'd2

// Number of RESP cycles waited before a synthetic all-ones response.
`define IOB_RR_TIMEOUT_LIMIT  8'd255

`endif

// File: rtl/iob_rr_arbiter_prio.sv
// Round-robin priority selector (purely combinational).
// Ports:
//   req        in  N_S  request vector, one bit per port
//   last_grant in  GW   port granted most recently
//   grant      out GW   first requesting port after last_grant, with wrap
//   any_req    out 1    at least one request bit is set
// The search starts at (last_grant+1) mod N_S, so last_grant itself has
// the lowest priority.
module iob_rr_arbiter_prio #(
  parameter int N_S = 2,
  parameter int GW  = (N_S > 1) ? $clog2(N_S) : 1
) (
  input  logic [N_S-1:0] req,
  input  logic [GW-1:0]  last_grant,
  output logic [GW-1:0]  grant,
  output logic           any_req
);

  int idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N_S; i++) begin
      idx = (int'(last_grant) + i) % N_S;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/iob_rr_arbiter_iob.sv
// IOb round-robin arbiter: shares one manager IOb port among N_S
// subordinate ports with a single outstanding transaction.
// Ports:
//   clk_i, arst_n_i          clock, asynchronous active-low reset
//   s_iob_valid_i  [N_S]     per-port request valid
//   s_iob_addr_i/wdata_i/wstrb_i  per-port request payload (slice k = port k)
//   s_iob_ready_o  [N_S]     per-port request accepted
//   s_iob_rvalid_o [N_S]     per-port read data valid
//   s_iob_rdata_o            manager read data broadcast to every slice
//   m_iob_*                  shared manager port
// Handshake: a request transfers on a cycle where valid and ready are both
// high; payload is only meaningful while valid is high. A write (nonzero
// wstrb) completes at transfer; a read completes on the single-cycle
// rvalid pulse that follows.
// Optional feature: define IOB_RR_ARBITER_IOB_TIMEOUT_EN to answer reads
// with all-ones data after 255 RESP cycles without m_iob_rvalid_i.
`include "iob_rr_arbiter_iob_conf.vh"

module iob_rr_arbiter_iob
  import iob_rr_arbiter_iob_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_S    = 2
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [N_S-1:0]           s_iob_valid_i,
  input  logic [N_S*ADDR_W-1:0]    s_iob_addr_i,
  input  logic [N_S*DATA_W-1:0]    s_iob_wdata_i,
  input  logic [N_S*DATA_W/8-1:0]  s_iob_wstrb_i,
  output logic [N_S-1:0]           s_iob_rvalid_o,
  output logic [N_S*DATA_W-1:0]    s_iob_rdata_o,
  output logic [N_S-1:0]           s_iob_ready_o,
  output logic                     m_iob_valid_o,
  output logic [ADDR_W-1:0]        m_iob_addr_o,
  output logic [DATA_W-1:0]        m_iob_wdata_o,
  output logic [DATA_W/8-1:0]      m_iob_wstrb_o,
  input  logic                     m_iob_rvalid_i,
  input  logic [DATA_W-1:0]        m_iob_rdata_i,
  input  logic                     m_iob_ready_i
);

  localparam int GW     = $clog2(N_S);
  localparam int STRB_W = DATA_W / 8;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_grant_q;
  logic [GW-1:0]   sel_grant;
  logic            any_req;

  logic              sel_valid;
  logic [STRB_W-1:0] sel_wstrb;
  logic              accept;
  logic              timeout;
  logic              resp_done;

  iob_rr_arbiter_prio #(
    .N_S (N_S),
    .GW  (GW)
  ) u_prio (
    .req        (s_iob_valid_i),
    .last_grant (last_grant_q),
    .grant      (sel_grant),
    .any_req    (any_req)
  );

  assign sel_valid = s_iob_valid_i[grant_q];
  assign sel_wstrb = s_iob_wstrb_i[grant_q*STRB_W +: STRB_W];
  assign accept    = (state_q == REQ) && sel_valid && m_iob_ready_i;

`ifdef IOB_RR_ARBITER_IOB_TIMEOUT_EN
  logic [7:0] resp_cnt_q;

  // Counts RESP cycles already spent waiting; cleared outside RESP.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      resp_cnt_q <= '0;
    end else if (state_q == RESP && !resp_done) begin
      resp_cnt_q <= resp_cnt_q + 8'd1;
    end else begin
      resp_cnt_q <= '0;
    end
  end

  assign timeout = (state_q == RESP) && (resp_cnt_q == `IOB_RR_TIMEOUT_LIMIT);
`else
  assign timeout = 1'b0;
`endif

  assign resp_done = (state_q == RESP) && (m_iob_rvalid_i || timeout);

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_S - 1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        grant_q <= sel_grant;
      end
      // The pointer only moves on an accepted request, so an abandoned
      // request does not cost the port its turn.
      if (accept) begin
        last_grant_q <= grant_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = REQ;
      end
      REQ: begin
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (m_iob_ready_i) begin
          state_d = (|sel_wstrb) ? IDLE : RESP;
        end
      end
      RESP: begin
        if (resp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_iob_valid_o  = 1'b0;
    m_iob_addr_o   = '0;
    m_iob_wdata_o  = '0;
    m_iob_wstrb_o  = '0;
    s_iob_ready_o  = '0;
    s_iob_rvalid_o = '0;
    if (state_q == REQ) begin
      m_iob_valid_o          = sel_valid;
      m_iob_addr_o           = s_iob_addr_i[grant_q*ADDR_W +: ADDR_W];
      m_iob_wdata_o          = s_iob_wdata_i[grant_q*DATA_W +: DATA_W];
      m_iob_wstrb_o          = sel_wstrb;
      s_iob_ready_o[grant_q] = m_iob_ready_i;
    end
    if (resp_done) begin
      s_iob_rvalid_o[grant_q] = 1'b1;
    end
  end

  // Read data goes to every port; only rvalid identifies the owner. A
  // timed-out read returns all ones unless real data arrives that cycle.
  always_comb begin
    s_iob_rdata_o = '0;
    for (int k = 0; k < N_S; k++) begin
      s_iob_rdata_o[k*DATA_W +: DATA_W] =
        (timeout && !m_iob_rvalid_i) ? {DATA_W{1'b1}} : m_iob_rdata_i;
    end
  end

endmodule

// File: doc/iob_rr_arbiter_iob.md
IOB_RR_ARBITER_IOB -- requirements
Module: iob_rr_arbiter_iob

Interface
REQ-001 Parameters SHALL be:
  ADDR_W, default 32, address width;
  DATA_W, default 32, data width (multiple of 8);
  N_S, default 2, number of subordinate ports (>=2).
REQ-002 Ports SHALL be (index k occupies slice k of every packed vector); one clock; reset is asynchronous and active-low:
  clk_i  in  1  clock
  arst_n_i  in  1  asynchronous active-low reset
  s_iob_valid_i  in  N_S  request valid per port
  s_iob_addr_i  in  N_S*ADDR_W  request address
  s_iob_wdata_i  in  N_S*DATA_W  write data
  s_iob_wstrb_i  in  N_S*DATA_W/8  write strobe; all-zero means read
  s_iob_rvalid_o  out  N_S  read data valid per port
  s_iob_rdata_o  out  N_S*DATA_W  read data
  s_iob_ready_o  out  N_S  request accepted per port
  m_iob_valid_o  out  1  shared manager request valid
  m_iob_addr_o  out  ADDR_W  manager address
  m_iob_wdata_o  out  DATA_W  manager write data
  m_iob_wstrb_o  out  DATA_W/8  manager write strobe
  m_iob_rvalid_i  in  1  manager read data valid
  m_iob_rdata_i  in  DATA_W  manager read data
  m_iob_ready_i  in  1  manager request accepted

Function
REQ-003 The block SHALL share one manager IOb port among N_S subordinate ports, one outstanding transaction at a time.
REQ-004 FSM states SHALL be IDLE, REQ, RESP.
REQ-005 IDLE: if any s_iob_valid_i bit is set, the block SHALL register grant = first set bit searching from (last_grant+1) mod N_S upward with wrap, then enter REQ; else stay.
REQ-006 REQ: m_iob_valid_o SHALL equal s_iob_valid_i[grant]; addr/wdata/wstrb SHALL be muxed from slice grant.
REQ-007 REQ: s_iob_ready_o[grant] SHALL equal m_iob_ready_i; all other ready bits SHALL be 0.
REQ-008 REQ accept (m_iob_valid_o & m_iob_ready_i): write (wstrb!=0) -> IDLE, read -> RESP; both SHALL set last_grant = grant.
REQ-009 REQ with s_iob_valid_i[grant] deasserted before accept SHALL return to IDLE without updating last_grant.
REQ-010 RESP: m_iob_valid_o SHALL be 0; on m_iob_rvalid_i, s_iob_rvalid_o[grant] SHALL be 1 that cycle and the FSM SHALL enter IDLE.
REQ-011 s_iob_rdata_o SHALL broadcast m_iob_rdata_i to every slice; rvalid SHALL be asserted only on the granted port, only in RESP.
REQ-012 Latency: manager valid SHALL appear one cycle after subordinate valid is sampled in IDLE; one IDLE cycle SHALL separate consecutive transactions.
REQ-013 m_iob_rvalid_i outside RESP SHALL be ignored.
REQ-014 Outside REQ, m_iob_valid_o and every s_iob_ready_o bit SHALL be 0; m_iob_addr_o/wdata_o/wstrb_o SHALL be 0 in IDLE and RESP.

Reset
REQ-015 On arst_n_i low: state=IDLE, grant=0, last_grant=N_S-1 (port 0 wins first), all valid/ready/rvalid outputs 0, addr/wdata/wstrb outputs 0.
REQ-016 Reset mid-transaction SHALL discard it; no rvalid SHALL be issued for it afterwards.

Configuration
REQ-017 With IOB_RR_ARBITER_IOB_TIMEOUT_EN defined, an 8-bit counter SHALL count RESP cycles; on reaching 255 without m_iob_rvalid_i, the block SHALL assert s_iob_rvalid_o[grant] with rdata all ones and enter IDLE.
REQ-018 Without the macro, RESP SHALL wait indefinitely and the counter SHALL not exist.

Structure
REQ-019 FSM state encodings and the timeout limit (255) SHALL live in the shared include iob_rr_arbiter_iob_conf.vh.
REQ-020 Round-robin selection SHALL be the combinational sub-module iob_rr_arbiter_prio (inputs req vector and last_grant; output grant index and any-request flag).

Verification
REQ-021 Scenario coverage:
  Single read on port 1, addr 0x10, ready same cycle, rvalid 2 cycles later with 0xCAFE -> s_iob_rvalid_o=2'b10, rdata 0xCAFE.
  Ports 0 and 1 both valid continuously, writes -> grants alternate 0,1,0,1, one IDLE cycle between.
  Port 0 write with m_iob_ready_i low 3 cycles -> s_iob_ready_o[0] stays 0, wstrb held, then accepted on cycle 4.
  arst_n_i pulsed low in RESP, late rvalid -> no s_iob_rvalid_o, state IDLE, next grant port 0.
  Spurious m_iob_rvalid_i in IDLE -> all s_iob_rvalid_o stay 0.
  Macro on, read never answered -> rvalid on granted port after 255 RESP cycles, rdata 0xFFFFFFFF.
